riscv_fwd_ctrl: RTL and testbench
=================================

// Module: riscv_fwd_ctrl
// PURPOSE
//  Operand-forwarding and load-use hazard controller for the 5-stage core. Tracks
//  destination regs of instructions in EX, MEM and WB. Generates registered 2-bit
//  selects for the two EX-stage 3:1 operand muxes. Raises a load-use stall to the
//  IF/ID stages. Keeps a saturating stall counter for performance debug.
// PARAMETERS
//  XLEN    32  datapath width (from riscv_param.v); sets o_stall_cnt width
//  RADDR_W 5   register-address width
// PORTS
//  i_clk         in   1        core clock; all state updates on posedge
//  i_rstn        in   1        reset, synchronous, active-low
//  i_id_valid    in   1        ID holds a valid instruction
//  i_id_rs1      in   RADDR_W  ID source reg 1
//  i_id_rs2      in   RADDR_W  ID source reg 2
//  i_id_rs1_use  in   1        instruction reads rs1
//  i_id_rs2_use  in   1        instruction reads rs2
//  i_id_rd       in   RADDR_W  ID destination reg
//  i_id_we       in   1        instruction writes rd
//  i_id_load     in   1        instruction is a load (result available after MEM)
//  i_hold        in   1        global pipeline freeze (e.g. memory wait)
//  i_flush       in   1        squash the ID instruction (taken branch/jump)
//  o_fwd_sel_a   out  2        EX operand A mux select
//  o_fwd_sel_b   out  2        EX operand B mux select
//  o_stall       out  1        load-use stall: hold PC and IF/ID, bubble into EX
//  o_stall_cnt   out  XLEN     saturating count of o_stall cycles
// BEHAVIOUR
//  - Select encoding: 00 = regfile, 01 = MEM/WB result, 10 = EX/MEM result.
//    11 is never driven.
//  - Tracking pipeline: EX, MEM and WB slots, each {rd, we, load}.
//    Advance on every clock with i_hold=0: EX<-ID entry, MEM<-EX, WB<-MEM.
//    The ID entry has we = i_id_we & i_id_valid.
//  - Bubble: when o_stall=1 or i_flush=1, the EX slot loads we=0, load=0.
//  - Select latency is 1 cycle. Selects are computed from the ID operands and
//    registered on advance, so they are valid while the instruction is in EX.
//    - Per operand, if use=1, rs!=0, EX.we=1 and rs==EX.rd: 10.
//      (This producer will be in EX/MEM when the consumer is in EX.)
//    - Else if use=1, rs!=0, MEM.we=1 and rs==MEM.rd: 01.
//    - Else 00.
//    - Youngest producer wins, so 10 has priority over 01. x0 is never forwarded.
//  - On i_flush or o_stall, the registered selects load 00 (the bubble reads the regfile).
//  - o_stall is combinational:
//    i_id_valid & EX.we & EX.load & EX.rd!=0 & ((rs1_use & rs1==EX.rd) | (rs2_use & rs2==EX.rd)) & ~i_flush.
//    The stall lasts exactly 1 cycle per hazard. On the next cycle the load is in MEM,
//    the ID compare re-evaluates and yields 01.
//  - i_hold=1: all slots, selects and the counter hold. o_stall is still driven.
//    i_hold overrides i_flush: the core keeps i_flush asserted until i_hold drops.
//  - o_stall_cnt increments when o_stall=1 and i_hold=0. It saturates at all-ones with no wrap.
//  - Reset (i_rstn=0 at posedge, valid mid-operation): all slots we=0, load=0, rd=0.
//    o_fwd_sel_a/b=00, o_stall_cnt=0. o_stall is therefore 0 after reset.
// CONFIGURATION
//  RISCV_WB_BYPASS_EN
//  - Defined: adds outputs o_id_byp_a and o_id_byp_b (1 bit each).
//    Each is asserted when WB.we=1, WB.rd!=0 and WB.rd equals the used ID rs.
//    They provide regfile write-through, so a same-cycle WB write is seen by ID.
//  - Undefined: these ports do not exist. The regfile must be write-first internally.
// TESTING
//  - Reset: hold i_rstn=0 for 2 clk with random inputs -> sel_a=sel_b=00, o_stall=0, o_stall_cnt=0.
//  - EX/MEM forward: add x5 then add x6,x5,x5 back-to-back -> while the consumer is in EX, sel_a=sel_b=10, o_stall=0.
//  - MEM/WB forward: add x5, nop, sub x7,x5,x1 -> sel_a=01, sel_b=00 in the consumer EX cycle.
//  - Priority and x0: add x5; add x5; or x8,x5,x0 -> sel_a=10 (youngest), sel_b=00.
//  - Load-use: lw x3; add x4,x3,x2 -> o_stall=1 for exactly 1 cycle, bubble sels 00, then sel_a=01; o_stall_cnt=1.
//  - Hold/flush: i_hold=1 for 3 cycles during a hazard -> sels and counter frozen; flush+load-use together -> o_stall=0, next sels 00.

Source files
------------

// File: rtl/riscv_fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 5-stage core.
// Optional WB write-through outputs under `RISCV_WB_BYPASS_EN.
module riscv_fwd_ctrl #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_id_valid,
  input  logic [RADDR_W-1:0] i_id_rs1,
  input  logic [RADDR_W-1:0] i_id_rs2,
  input  logic               i_id_rs1_use,
  input  logic               i_id_rs2_use,
  input  logic [RADDR_W-1:0] i_id_rd,
  input  logic               i_id_we,
  input  logic               i_id_load,
  input  logic               i_hold,
  input  logic               i_flush,
  output logic [1:0]         o_fwd_sel_a,
  output logic [1:0]         o_fwd_sel_b,
  output logic               o_stall,
  output logic [XLEN-1:0]    o_stall_cnt
`ifdef RISCV_WB_BYPASS_EN
  ,
  output logic               o_id_byp_a,
  output logic               o_id_byp_b
`endif
);

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic               we;
    logic               load;
  } slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;
  logic [1:0] sel_a_q, sel_b_q;
  logic [1:0] sel_a_d, sel_b_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic bubble;
  logic hit1, hit2;

  // EX producer lands in EX/MEM, MEM producer in MEM/WB, by the consumer's EX cycle
  function automatic logic [1:0] sel_f(
    input logic               u,
    input logic [RADDR_W-1:0] rs,
    input slot_t              ex,
    input slot_t              mem
  );
    logic [1:0] s;
    s = SEL_RF;
    if (u && rs != '0) begin
      if (ex.we && rs == ex.rd)
        s = SEL_MEM;
      else if (mem.we && rs == mem.rd)
        s = SEL_WB;
    end
    return s;
  endfunction

  always_comb begin
    hit1 = i_id_rs1_use && (i_id_rs1 == ex_q.rd);
    hit2 = i_id_rs2_use && (i_id_rs2 == ex_q.rd);
    o_stall = i_id_valid && ex_q.we && ex_q.load
           && (ex_q.rd != '0) && (hit1 || hit2)
           && !i_flush;
    bubble = o_stall || i_flush;
  end

  always_comb begin
    ex_d.rd   = i_id_rd;
    ex_d.we   = i_id_we && i_id_valid && !bubble;
    ex_d.load = i_id_load && !bubble;
    sel_a_d   = SEL_RF;
    sel_b_d   = SEL_RF;
    if (!bubble) begin
      sel_a_d = sel_f(i_id_rs1_use, i_id_rs1, ex_q, mem_q);
      sel_b_d = sel_f(i_id_rs2_use, i_id_rs2, ex_q, mem_q);
    end
    cnt_d = cnt_q;
    if (o_stall && cnt_q != '1)
      cnt_d = cnt_q + XLEN'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else if (!i_hold) begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_fwd_sel_a = sel_a_q;
  assign o_fwd_sel_b = sel_b_q;
  assign o_stall_cnt = cnt_q;

`ifdef RISCV_WB_BYPASS_EN
  assign o_id_byp_a = wb_q.we && (wb_q.rd != '0)
                   && i_id_rs1_use && (i_id_rs1 == wb_q.rd);
  assign o_id_byp_b = wb_q.we && (wb_q.rd != '0)
                   && i_id_rs2_use && (i_id_rs2 == wb_q.rd);
`endif

endmodule

// File: tb/tb_riscv_fwd_ctrl.sv
// Directed and random checks of riscv_fwd_ctrl against a
// queue-style pipeline model.
module tb_riscv_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       v;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, we, ld;
  logic       hold, flush;
  logic [1:0] sel_a, sel_b;
  logic       stall;
  logic [31:0] cnt;
`ifdef RISCV_WB_BYPASS_EN
  logic       byp_a, byp_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_fwd_ctrl #(.XLEN(32), .RADDR_W(5)) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_id_valid(v),
    .i_id_rs1(rs1),
    .i_id_rs2(rs2),
    .i_id_rs1_use(u1),
    .i_id_rs2_use(u2),
    .i_id_rd(rd),
    .i_id_we(we),
    .i_id_load(ld),
    .i_hold(hold),
    .i_flush(flush),
    .o_fwd_sel_a(sel_a),
    .o_fwd_sel_b(sel_b),
    .o_stall(stall),
    .o_stall_cnt(cnt)
`ifdef RISCV_WB_BYPASS_EN
    ,
    .o_id_byp_a(byp_a),
    .o_id_byp_b(byp_b)
`endif
  );

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  typedef struct {
    logic [4:0] rd;
    bit         we;
    bit         ld;
  } ent_t;

  ent_t        pipe[3];
  logic [1:0]  m_a, m_b;
  logic [31:0] m_cnt;

  task automatic m_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '{5'd0, 1'b0, 1'b0};
    m_a = 2'b00;
    m_b = 2'b00;
    m_cnt = 32'd0;
  endtask

  function automatic bit m_stall();
    bit h;
    h = (u1 && rs1 == pipe[0].rd) || (u2 && rs2 == pipe[0].rd);
    return v && pipe[0].we && pipe[0].ld && pipe[0].rd != 0 && h && !flush;
  endfunction

  // youngest writer of rs among EX/MEM; EX -> 10, MEM -> 01
  function automatic logic [1:0] m_sel(bit u, logic [4:0] rs);
    if (!u || rs == 0) return 2'b00;
    for (int k = 0; k < 2; k++)
      if (pipe[k].we && pipe[k].rd == rs)
        return (k == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_byp(bit u, logic [4:0] rs);
    return pipe[2].we && pipe[2].rd != 0 && u && rs == pipe[2].rd;
  endfunction

  task automatic m_clock();
    bit s, b;
    logic [1:0] na, nb;
    if (!rstn) begin
      m_clear();
    end else if (!hold) begin
      s = m_stall();
      b = s || flush;
      na = b ? 2'b00 : m_sel(u1, rs1);
      nb = b ? 2'b00 : m_sel(u2, rs2);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{rd, we && v && !b, ld && !b};
      m_a = na;
      m_b = nb;
      if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("m_sel_a", {30'd0, sel_a}, {30'd0, m_a});
    chk("m_sel_b", {30'd0, sel_b}, {30'd0, m_b});
    chk("m_stall", {31'd0, stall}, {31'd0, m_stall()});
    chk("m_cnt", cnt, m_cnt);
`ifdef RISCV_WB_BYPASS_EN
    chk("m_byp_a", {31'd0, byp_a}, {31'd0, m_byp(u1, rs1)});
    chk("m_byp_b", {31'd0, byp_b}, {31'd0, m_byp(u2, rs2)});
`endif
  endtask

  // one clock: model check at negedge, model advance at posedge
  task automatic cyc();
    @(negedge clk);
    chk_model();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic id(logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                    bit a1, bit a2, bit w, bit l);
    v = 1'b1; rd = d; rs1 = s1; rs2 = s2;
    u1 = a1; u2 = a2; we = w; ld = l;
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic nop();
    id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    v = 1'b0;
  endtask

  task automatic rnd_in();
    v = 1'($urandom);
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    u1 = 1'($urandom); u2 = 1'($urandom);
    we = 1'($urandom); ld = 1'($urandom);
    hold = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    rstn = 1'b0;
    m_clear();
    rnd_in();
    @(posedge clk); #1;
    rnd_in();
    @(posedge clk); #1;
    m_clear();
    chk("rst_sel_a", {30'd0, sel_a}, 32'd0);
    chk("rst_sel_b", {30'd0, sel_b}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    rstn = 1'b1;
    nop(); cyc(); cyc(); cyc();

    // EX/MEM forward
    id(5, 1, 2, 1, 1, 1, 0); cyc();
    id(6, 5, 5, 1, 1, 1, 0); cyc();
    nop(); #1;
    chk("exmem_a", {30'd0, sel_a}, 32'd2);
    chk("exmem_b", {30'd0, sel_b}, 32'd2);
    chk("exmem_stall", {31'd0, stall}, 32'd0);
    cyc(); cyc(); cyc();

    // MEM/WB forward
    id(5, 1, 2, 1, 1, 1, 0); cyc();
    nop(); cyc();
    id(7, 5, 1, 1, 1, 1, 0); cyc();
    chk("memwb_a", {30'd0, sel_a}, 32'd1);
    chk("memwb_b", {30'd0, sel_b}, 32'd0);
    nop(); cyc(); cyc(); cyc();

    // priority and x0
    id(5, 1, 2, 1, 1, 1, 0); cyc();
    id(5, 3, 4, 1, 1, 1, 0); cyc();
    id(8, 5, 0, 1, 1, 1, 0); cyc();
    chk("prio_a", {30'd0, sel_a}, 32'd2);
    chk("prio_b", {30'd0, sel_b}, 32'd0);
    nop(); cyc(); cyc(); cyc();

    // load-use
    id(3, 1, 0, 1, 0, 1, 1); cyc();
    id(4, 3, 2, 1, 1, 1, 0); #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    cyc();
    chk("lu_bub_a", {30'd0, sel_a}, 32'd0);
    chk("lu_bub_b", {30'd0, sel_b}, 32'd0);
    chk("lu_stall2", {31'd0, stall}, 32'd0);
    cyc();
    chk("lu_fwd_a", {30'd0, sel_a}, 32'd1);
    chk("lu_fwd_b", {30'd0, sel_b}, 32'd0);
    chk("lu_cnt", cnt, 32'd1);
    nop(); cyc(); cyc(); cyc();

    // hold during a hazard
    id(3, 1, 0, 1, 0, 1, 1); cyc();
    id(4, 3, 2, 1, 1, 1, 0); hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_stall", {31'd0, stall}, 32'd1);
      chk("hold_a", {30'd0, sel_a}, 32'd0);
      chk("hold_cnt", cnt, 32'd1);
    end
    hold = 1'b0; cyc();
    chk("unhold_cnt", cnt, 32'd2);
    cyc();
    chk("unhold_a", {30'd0, sel_a}, 32'd1);
    nop(); cyc(); cyc(); cyc();

    // flush with load-use
    id(9, 1, 0, 1, 0, 1, 1); cyc();
    id(4, 9, 9, 1, 1, 1, 0); flush = 1'b1; #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    cyc();
    chk("fl_a", {30'd0, sel_a}, 32'd0);
    chk("fl_b", {30'd0, sel_b}, 32'd0);
    chk("fl_cnt", cnt, 32'd2);
    nop(); cyc();

    // random traffic with occasional mid-run reset
    for (int i = 0; i < 600; i++) begin
      rnd_in();
      rstn = ($urandom_range(0, 63) != 0);
      cyc();
    end
    rstn = 1'b1;
    nop(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
